// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared state encoding, default stage masks and mask lookup helper
// Rev 1.0
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INTRO   = 3'd1,
        PLAY    = 3'd2,
        PAUSED  = 3'd3,
        RESPAWN = 3'd4,
        WON     = 3'd5,
        OVER    = 3'd6
    } game_state_t;

    // Masks are carried as 8 bits so any NUM_STAGES up to 8 can index them.
    localparam logic [7:0] C_DEF_MONST_MASK  = 8'b0000_0111;
    localparam logic [7:0] C_DEF_BOSS_MASK   = 8'b0000_1000;
    localparam logic [7:0] C_DEF_ASTERO_MASK = 8'b0000_1010;

    function automatic logic mask_bit(input logic [7:0] m, input logic [2:0] s);
        return m[s];
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// frame_timer : counts frame ticks up to a limit, held at zero while cleared
// Rev 1.0
// ============================================================================
module frame_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == (i_limit - CNT_W'(1)));
    assign o_done = i_tick && !i_clr && w_last;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule : frame_timer
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// game_sequencer : stage / lives sequencer driving object subsystem enables
// Rev 1.0
// ============================================================================
module game_sequencer
    import game_pkg::*;
#(
    parameter int         NUM_STAGES     = 4,
    parameter int         STAGE_W        = $clog2(NUM_STAGES) + 1,
    parameter int         NUM_LIVES      = 3,
    parameter int         LIVES_W        = 4,
    parameter logic [7:0] MONST_MASK     = C_DEF_MONST_MASK,
    parameter logic [7:0] BOSS_MASK      = C_DEF_BOSS_MASK,
    parameter logic [7:0] ASTERO_MASK    = C_DEF_ASTERO_MASK,
    parameter int         INTRO_FRAMES   = 60,
    parameter int         RESPAWN_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               start_game,
    input  logic               pause,
    input  logic               skip_stage,
    input  logic               player_dead,
    input  logic               win_stage,
    output logic               enable_player,
    output logic               enable_monst,
    output logic               enable_boss,
    output logic               enable_astero,
    output logic               resetN_player,
    output logic               resetN_monst,
    output logic [STAGE_W-1:0] stage_num,
    output logic [LIVES_W-1:0] lives,
    output logic               game_won,
    output logic               game_over
);

    localparam int C_MAX_FRAMES = (INTRO_FRAMES > RESPAWN_FRAMES) ? INTRO_FRAMES : RESPAWN_FRAMES;
    localparam int C_CNT_W      = $clog2(C_MAX_FRAMES + 1);

    localparam logic [STAGE_W-1:0] C_LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic [LIVES_W-1:0] C_FULL_LIVES = LIVES_W'(NUM_LIVES);

    game_state_t        r_state;
    logic [STAGE_W-1:0] r_stage;
    logic [LIVES_W-1:0] r_lives;
    logic               r_start_d;
    logic               r_pause_d;
    logic               r_skip_d;
    logic               r_en_player;
    logic               r_en_monst;
    logic               r_en_boss;
    logic               r_en_astero;
    logic               r_rstn_player;
    logic               r_rstn_monst;
    logic               r_won;
    logic               r_over;

    game_state_t        w_next_state;
    logic [STAGE_W-1:0] w_next_stage;
    logic [LIVES_W-1:0] w_next_lives;
    logic [2:0]         w_stage_idx;
    logic               w_start_edge;
    logic               w_pause_edge;
    logic               w_skip_edge;
    logic               w_timed;
    logic [C_CNT_W-1:0] w_limit;
    logic               w_timer_done;

    assign w_start_edge = start_game && !r_start_d;
    assign w_pause_edge = pause      && !r_pause_d;
    assign w_skip_edge  = skip_stage && !r_skip_d;

    // Only timed states count; leaving them clears the timer, so every entry starts at zero.
    assign w_timed = (r_state == INTRO) || (r_state == RESPAWN);
    assign w_limit = (r_state == INTRO) ? C_CNT_W'(INTRO_FRAMES) : C_CNT_W'(RESPAWN_FRAMES);

    frame_timer #(
        .CNT_W (C_CNT_W)
    ) u_frame_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (!w_timed),
        .i_tick  (startOfFrame),
        .i_limit (w_limit),
        .o_done  (w_timer_done)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_stage = r_stage;
        w_next_lives = r_lives;
        case (r_state)
            IDLE, WON, OVER: begin
                if (w_start_edge) begin
                    w_next_state = INTRO;
                    w_next_stage = '0;
                    w_next_lives = C_FULL_LIVES;
                end
            end
            INTRO: begin
                if (w_timer_done) w_next_state = PLAY;
            end
            PLAY: begin
                // One event per cycle; lower-priority events are dropped.
                if (player_dead) begin
                    if (r_lives <= LIVES_W'(1)) begin
                        w_next_state = OVER;
                        w_next_lives = '0;
                    end else begin
                        w_next_state = RESPAWN;
                        w_next_lives = r_lives - LIVES_W'(1);
                    end
                end else if (win_stage || w_skip_edge) begin
                    if (r_stage >= C_LAST_STAGE) begin
                        w_next_state = WON;
                    end else begin
                        w_next_state = INTRO;
                        w_next_stage = r_stage + STAGE_W'(1);
                    end
                end else if (w_pause_edge) begin
                    w_next_state = PAUSED;
                end
            end
            PAUSED: begin
                if (w_pause_edge) w_next_state = PLAY;
            end
            RESPAWN: begin
                if (w_timer_done) w_next_state = PLAY;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_stage_idx = 3'(w_next_stage);

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_stage       <= '0;
            r_lives       <= C_FULL_LIVES;
            r_start_d     <= 1'b0;
            r_pause_d     <= 1'b0;
            r_skip_d      <= 1'b0;
            r_en_player   <= 1'b0;
            r_en_monst    <= 1'b0;
            r_en_boss     <= 1'b0;
            r_en_astero   <= 1'b0;
            r_rstn_player <= 1'b0;
            r_rstn_monst  <= 1'b0;
            r_won         <= 1'b0;
            r_over        <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_stage   <= w_next_stage;
            r_lives   <= w_next_lives;
            r_start_d <= start_game;
            r_pause_d <= pause;
            r_skip_d  <= skip_stage;

            r_en_player   <= 1'b0;
            r_en_monst    <= 1'b0;
            r_en_boss     <= 1'b0;
            r_en_astero   <= 1'b0;
            r_rstn_player <= 1'b1;
            r_rstn_monst  <= 1'b1;
            r_won         <= 1'b0;
            r_over        <= 1'b0;
            case (w_next_state)
                IDLE, INTRO: begin
                    r_rstn_player <= 1'b0;
                    r_rstn_monst  <= 1'b0;
                end
                PLAY: begin
                    r_en_player <= 1'b1;
                    r_en_monst  <= mask_bit(MONST_MASK,  w_stage_idx);
                    r_en_boss   <= mask_bit(BOSS_MASK,   w_stage_idx);
                    r_en_astero <= mask_bit(ASTERO_MASK, w_stage_idx);
                end
                RESPAWN: r_rstn_player <= 1'b0;
                WON:     r_won         <= 1'b1;
                OVER:    r_over        <= 1'b1;
                default: ;
            endcase
        end
    end

    assign enable_player = r_en_player;
    assign enable_monst  = r_en_monst;
    assign enable_boss   = r_en_boss;
    assign enable_astero = r_en_astero;
    assign resetN_player = r_rstn_player;
    assign resetN_monst  = r_rstn_monst;
    assign stage_num     = r_stage;
    assign lives         = r_lives;
    assign game_won      = r_won;
    assign game_over     = r_over;

endmodule : game_sequencer
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// tb_game_sequencer : directed scenarios for game_sequencer with default params
// Rev 1.0
// ============================================================================
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset, startOfFrame, start_game, pause, skip_stage, player_dead, win_stage;
    logic       enable_player, enable_monst, enable_boss, enable_astero;
    logic       resetN_player, resetN_monst, game_won, game_over;
    logic [2:0] stage_num;
    logic [3:0] lives;
    logic [7:0] w_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {en_player,en_monst,en_boss,en_astero,rstN_player,rstN_monst,won,over}
    localparam logic [7:0] C_IDLE    = 8'b0000_0000;
    localparam logic [7:0] C_PLAY0   = 8'b1100_1100;
    localparam logic [7:0] C_PLAY1   = 8'b1101_1100;
    localparam logic [7:0] C_PLAY2   = 8'b1100_1100;
    localparam logic [7:0] C_PLAY3   = 8'b1011_1100;
    localparam logic [7:0] C_PAUSED  = 8'b0000_1100;
    localparam logic [7:0] C_RESPAWN = 8'b0000_0100;
    localparam logic [7:0] C_WON     = 8'b0000_1110;
    localparam logic [7:0] C_OVER    = 8'b0000_1101;

    assign w_out = {enable_player, enable_monst, enable_boss, enable_astero,
                    resetN_player, resetN_monst, game_won, game_over};

    always #5 clk = ~clk;

    game_sequencer u_dut (
        .clk           (clk),
        .reset         (reset),
        .startOfFrame  (startOfFrame),
        .start_game    (start_game),
        .pause         (pause),
        .skip_stage    (skip_stage),
        .player_dead   (player_dead),
        .win_stage     (win_stage),
        .enable_player (enable_player),
        .enable_monst  (enable_monst),
        .enable_boss   (enable_boss),
        .enable_astero (enable_astero),
        .resetN_player (resetN_player),
        .resetN_monst  (resetN_monst),
        .stage_num     (stage_num),
        .lives         (lives),
        .game_won      (game_won),
        .game_over     (game_over)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            step();
        end
    endtask

    task automatic pulse_start();
        start_game = 1'b1; step(); start_game = 1'b0; step();
    endtask

    task automatic pulse_win();
        win_stage = 1'b1; step(); win_stage = 1'b0; step();
    endtask

    task automatic pulse_dead();
        player_dead = 1'b1; step(); player_dead = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; startOfFrame = 0; start_game = 0; pause = 0;
        skip_stage = 0; player_dead = 0; win_stage = 0;
        step(); step();
        reset = 1'b0;
        n_checks++;
        if (w_out !== C_IDLE) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", w_out, C_IDLE); end
        n_checks++;
        if (lives !== 4'd3 || stage_num !== 3'd0) begin
            n_fail++; $display("FAIL reset_counters: lives %0d stage %0d want 3 0", lives, stage_num);
        end
    endtask

    task automatic test_intro();
        pulse_start();
        frames(59);
        n_checks++;
        if (w_out !== C_IDLE) begin n_fail++; $display("FAIL intro_59_frames: got %b want %b", w_out, C_IDLE); end
        frames(1);
        n_checks++;
        if (w_out !== C_PLAY0 || lives !== 4'd3 || stage_num !== 3'd0) begin
            n_fail++; $display("FAIL intro_to_play: got %b lives %0d stage %0d want %b 3 0", w_out, lives, stage_num, C_PLAY0);
        end
    endtask

    task automatic test_lives();
        pulse_dead();
        n_checks++;
        if (w_out !== C_RESPAWN || lives !== 4'd2) begin
            n_fail++; $display("FAIL respawn_1: got %b lives %0d want %b 2", w_out, lives, C_RESPAWN);
        end
        frames(29);
        n_checks++;
        if (w_out !== C_RESPAWN) begin n_fail++; $display("FAIL respawn_29_frames: got %b want %b", w_out, C_RESPAWN); end
        frames(1);
        n_checks++;
        if (w_out !== C_PLAY0) begin n_fail++; $display("FAIL respawn_to_play: got %b want %b", w_out, C_PLAY0); end
        pulse_dead();
        n_checks++;
        if (w_out !== C_RESPAWN || lives !== 4'd1) begin
            n_fail++; $display("FAIL respawn_2: got %b lives %0d want %b 1", w_out, lives, C_RESPAWN);
        end
        frames(30);
        pulse_dead();
        n_checks++;
        if (w_out !== C_OVER || lives !== 4'd0) begin
            n_fail++; $display("FAIL game_over: got %b lives %0d want %b 0", w_out, lives, C_OVER);
        end
    endtask

    task automatic test_stages();
        pulse_start();
        n_checks++;
        if (w_out !== C_IDLE || lives !== 4'd3 || stage_num !== 3'd0) begin
            n_fail++; $display("FAIL restart_from_over: got %b lives %0d stage %0d", w_out, lives, stage_num);
        end
        frames(60);
        pulse_win();
        n_checks++;
        if (stage_num !== 3'd1 || w_out !== C_IDLE) begin
            n_fail++; $display("FAIL win_stage0: stage %0d out %b want 1 %b", stage_num, w_out, C_IDLE);
        end
        frames(60);
        n_checks++;
        if (w_out !== C_PLAY1) begin n_fail++; $display("FAIL play_stage1: got %b want %b", w_out, C_PLAY1); end
        pulse_win();
        frames(60);
        n_checks++;
        if (w_out !== C_PLAY2 || stage_num !== 3'd2) begin
            n_fail++; $display("FAIL play_stage2: got %b stage %0d want %b 2", w_out, stage_num, C_PLAY2);
        end
        skip_stage = 1'b1; step(); skip_stage = 1'b0; step();
        frames(60);
        n_checks++;
        if (w_out !== C_PLAY3 || stage_num !== 3'd3) begin
            n_fail++; $display("FAIL skip_to_stage3: got %b stage %0d want %b 3", w_out, stage_num, C_PLAY3);
        end
        pulse_win();
        n_checks++;
        if (w_out !== C_WON || stage_num !== 3'd3) begin
            n_fail++; $display("FAIL game_won: got %b stage %0d want %b 3", w_out, stage_num, C_WON);
        end
    endtask

    task automatic test_same_cycle();
        pulse_start();
        frames(60);
        pulse_dead();
        frames(30);
        pulse_win();
        frames(60);
        n_checks++;
        if (w_out !== C_PLAY1 || lives !== 4'd2) begin
            n_fail++; $display("FAIL setup_stage1: got %b lives %0d want %b 2", w_out, lives, C_PLAY1);
        end
        player_dead = 1'b1; win_stage = 1'b1;
        step();
        player_dead = 1'b0; win_stage = 1'b0;
        n_checks++;
        if (w_out !== C_RESPAWN || lives !== 4'd1 || stage_num !== 3'd1) begin
            n_fail++; $display("FAIL dead_beats_win: got %b lives %0d stage %0d want %b 1 1", w_out, lives, stage_num, C_RESPAWN);
        end
        frames(30);
    endtask

    task automatic test_pause();
        pause = 1'b1; step();
        n_checks++;
        if (w_out !== C_PAUSED) begin n_fail++; $display("FAIL pause_enter: got %b want %b", w_out, C_PAUSED); end
        repeat (10) step();
        pulse_dead();
        n_checks++;
        if (w_out !== C_PAUSED || lives !== 4'd1) begin
            n_fail++; $display("FAIL pause_held: got %b lives %0d want %b 1", w_out, lives, C_PAUSED);
        end
        pause = 1'b0; step();
        pause = 1'b1; step();
        n_checks++;
        if (w_out !== C_PLAY1 || lives !== 4'd1 || stage_num !== 3'd1) begin
            n_fail++; $display("FAIL pause_resume: got %b lives %0d stage %0d want %b 1 1", w_out, lives, stage_num, C_PLAY1);
        end
        pause = 1'b0; step();
    endtask

    task automatic test_reset_midgame();
        pulse_win();
        frames(60);
        pause = 1'b1; step(); pause = 1'b0; step();
        n_checks++;
        if (w_out !== C_PAUSED || stage_num !== 3'd2) begin
            n_fail++; $display("FAIL paused_stage2: got %b stage %0d want %b 2", w_out, stage_num, C_PAUSED);
        end
        reset = 1'b1; step();
        n_checks++;
        if (w_out !== C_IDLE || stage_num !== 3'd0 || lives !== 4'd3) begin
            n_fail++; $display("FAIL reset_midgame: got %b stage %0d lives %0d want %b 0 3", w_out, stage_num, lives, C_IDLE);
        end
        reset = 1'b0; step();
        pulse_start();
        frames(60);
        n_checks++;
        if (w_out !== C_PLAY0 || stage_num !== 3'd0 || lives !== 4'd3) begin
            n_fail++; $display("FAIL play_after_reset: got %b stage %0d lives %0d want %b 0 3", w_out, stage_num, lives, C_PLAY0);
        end
    endtask

    initial begin
        test_reset();
        test_intro();
        test_lives();
        test_stages();
        test_same_cycle();
        test_pause();
        test_reset_midgame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_game_sequencer
`default_nettype wire

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Parametrised successor to the fixed game controller: sequences a configurable number of stages, tracks player lives, and drives per-subsystem enables and clears for player, monsters, boss and asteroids. Per-stage object mix comes from bit masks. Timed intro and respawn phases are counted in frames via startOfFrame. Sits between the top level and the object subsystems, replacing the previous controller.

Parameters:
NUM_STAGES, 4, number of stages (1..8).
STAGE_W, $clog2(NUM_STAGES)+1, width of stage_num.
NUM_LIVES, 3, lives at game start (1..15).
LIVES_W, 4, width of the lives counter.
MONST_MASK, 4'b0111, bit s=1: monsters active in stage s.
BOSS_MASK, 4'b1000, bit s=1: boss active in stage s.
ASTERO_MASK, 4'b1010, bit s=1: asteroids active in stage s.
INTRO_FRAMES, 60, frames spent in the stage intro.
RESPAWN_FRAMES, 30, frames spent in respawn.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
startOfFrame  in  1  one-cycle frame tick
start_game  in  1  level; rising edge detected internally
pause  in  1  level; each rising edge toggles pause
skip_stage  in  1  level; rising edge = cheat advance
player_dead  in  1  pulse: player hit
win_stage  in  1  level: all stage enemies dead
enable_player  out  1  player subsystem enable
enable_monst  out  1  monsters enable
enable_boss  out  1  boss enable
enable_astero  out  1  asteroids enable
resetN_player  out  1  active-low clear to player
resetN_monst  out  1  active-low clear to monsters, boss and asteroids
stage_num  out  STAGE_W  current stage, 0-based
lives  out  LIVES_W  remaining lives
game_won  out  1  level while in WON
game_over  out  1  level while in OVER

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE, stage_num=0, lives=NUM_LIVES.
  - all enables=0.
  - resetN_player=0, resetN_monst=0.
  - game_won=0, game_over=0.
  - frame counter=0, edge-detect registers=0.
- Edge detect: a rising edge is the input high while its 1-cycle-delayed copy is low.
- States:
  - IDLE: start_game edge -> INTRO, stage_num=0, lives=NUM_LIVES.
  - INTRO: both clears asserted (resetN_*=0), enables 0. The counter increments on startOfFrame; at INTRO_FRAMES-1 with startOfFrame -> PLAY, counter=0.
  - PLAY: resetN_*=1.
    - enable_player=1.
    - enable_monst=MONST_MASK[stage_num], enable_boss=BOSS_MASK[stage_num], enable_astero=ASTERO_MASK[stage_num].
  - PAUSED: all enables 0 and clears deasserted, so object state is held. A pause edge returns to PLAY.
  - RESPAWN: resetN_player=0, other clears deasserted, all enables 0. After RESPAWN_FRAMES frames -> PLAY.
  - WON and OVER: enables 0, the matching flag is 1. A start_game edge -> INTRO with a fresh game (stage 0, full lives).
- PLAY priority, highest first, one event per cycle:
  1. player_dead: lives-1. If lives was 1 -> OVER (lives=0); otherwise -> RESPAWN.
  2. win_stage or skip_stage edge: if stage_num==NUM_STAGES-1 -> WON; otherwise stage_num+1 -> INTRO.
  3. pause edge -> PAUSED.
- Lower-priority events in the same cycle are dropped, not queued.
- player_dead, win_stage and skip_stage are ignored outside PLAY. pause is ignored outside PLAY and PAUSED.
- The frame counter clears on every state entry. Its width is wide enough for max(INTRO_FRAMES, RESPAWN_FRAMES).
- Mask bits at index ≥ NUM_STAGES are unused.
- stage_num never exceeds NUM_STAGES-1 and lives never underflows.
- Reset mid-game returns to IDLE on the next edge, whatever the state.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic [2:0] game_state_t {IDLE, INTRO, PLAY, PAUSED, RESPAWN, WON, OVER};
  - the default mask constants.
- One sub-module, frame_timer: counts startOfFrame ticks up to a programmable limit, clears on start, outputs a done pulse. It is shared by INTRO and RESPAWN.

Test Plan:
1. Reset, start_game pulse, 60 startOfFrame ticks -> PLAY at stage 0: enable_monst=1, enable_boss=0, enable_astero=0, lives=3.
2. In PLAY at stage 0, player_dead ×3 with 30 frames between -> RESPAWN twice with lives 2 then 1; third hit -> game_over=1, lives=0, all enables 0.
3. win_stage in stages 0, 1 and 2 -> stage_num 1, 2, 3. Stage 3 gives enable_boss=1, enable_astero=1, enable_monst=0. win_stage at stage 3 -> game_won=1.
4. player_dead and win_stage in the same cycle at stage 1 with lives=2 -> RESPAWN, lives=1, stage_num stays 1.
5. pause edge in PLAY -> all enables 0, resetN_*=1. pause held high for 10 cycles causes no extra toggle. A second edge returns to PLAY with the same stage and lives.
6. Assert reset while PAUSED at stage 2 -> next cycle state IDLE, stage_num=0, lives=3, all outputs at reset values. start_game edge in OVER -> INTRO with a fresh game.
